// File: rtl/alu_pkg.sv
// Shared definitions for the TotalALU front-end sequencer: function codes,
// sequencer state encoding and the operation classes produced by the decoder.
// Imported by the sequencer, its decoder and the testbench scoreboard.
package alu_pkg;

  // Datapath function codes (6-bit Signal input of TotalALU)
  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_SLL   = 6'd0;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  // Decodes to no datapath unit; driven whenever nothing is active
  localparam logic [5:0] FN_IDLE  = 6'b111111;

  // Sequencer states, kept as plain constants so the encoding is stable
  // for anything that probes the state register directly.
  typedef logic [2:0] seqState_t;
  localparam seqState_t ST_IDLE      = 3'd0;
  localparam seqState_t ST_ISSUE     = 3'd1;
  localparam seqState_t ST_MUL_RUN   = 3'd2;
  localparam seqState_t ST_HILO_WAIT = 3'd3;
  localparam seqState_t ST_RESP      = 3'd4;

  // What the sequencer has to do with a function code
  typedef enum logic [1:0] {
    OP_SINGLE  = 2'd0,  // one-cycle ALU/shift operation
    OP_MUL     = 2'd1,  // multi-cycle shift-add multiply into HiLo
    OP_HILO_RD = 2'd2,  // read of HiLo, legal only after a finished MULTU
    OP_ILLEGAL = 2'd3   // not a code the datapath understands
  } opClass_t;

endpackage

// File: rtl/alu_funct_decode.sv
// Purpose: classify a 6-bit TotalALU function code into an operation class.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the input every cycle.
// Ports:
//   funct   in  6  function code
//   opClass out 2  SINGLE / MUL / HILO_RD / ILLEGAL
module alu_funct_decode
  import alu_pkg::*;
(
  input  logic [5:0] funct,
  output opClass_t   opClass
);

  always_comb begin
    opClass = OP_ILLEGAL;
    case (funct)
      FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_SLL: opClass = OP_SINGLE;
      FN_MULTU:                                      opClass = OP_MUL;
      FN_MFHI, FN_MFLO:                              opClass = OP_HILO_RD;
      default:                                       opClass = OP_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/alu_op_sequencer.sv
// Purpose: issue one operation at a time into the TotalALU datapath and return its result.
// Latency: rsp_valid 1 cycle after accept for errors, 2 for single-cycle ops and
//          HiLo reads, 1+MUL_CYCLES+HILO_LAT for MULTU.
// Backpressure: req_ready only in IDLE; the response is held stable until rsp_ready.
// Ports:
//   clk, reset (sync, active-low)
//   req_valid/req_ready/req_funct/req_a/req_b   request channel
//   dp_signal/dp_dataA/dp_dataB/dp_result       datapath drive and result
//   rsp_valid/rsp_ready/rsp_data/rsp_err        response channel
//   busy                                        high outside IDLE
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int         MUL_CYCLES = 32,
  parameter int         HILO_LAT   = 1,
  parameter logic [5:0] IDLE_CODE  = FN_IDLE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_funct,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic [5:0]  dp_signal,
  output logic [31:0] dp_dataA,
  output logic [31:0] dp_dataB,
  input  logic [31:0] dp_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        busy
);

  // One counter serves both the multiply phase and the HiLo settle phase,
  // and is sized so the longer of the two can never wrap.
  localparam int CNT_W = $clog2(MUL_CYCLES + HILO_LAT + 1);
  localparam logic [CNT_W-1:0] MUL_LAST  = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] HILO_LAST = CNT_W'(HILO_LAT - 1);

  seqState_t        state;
  logic [CNT_W-1:0] counter;
  logic             hiloValid;   // HiLo holds a completed product
  logic [5:0]       functReg;
  opClass_t         reqClass;
  logic             accept;

  alu_funct_decode uDecode (
    .funct   (req_funct),
    .opClass (reqClass)
  );

  assign req_ready = (state == ST_IDLE);
  assign accept    = req_valid && req_ready;
  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

  // Only the function code returns to idle between operations; operands
  // stay on the datapath bus until the next legal operation replaces them.
  always_comb begin
    dp_signal = IDLE_CODE;
    case (state)
      ST_ISSUE:   dp_signal = functReg;
      ST_MUL_RUN: dp_signal = FN_MULTU;
      default:    dp_signal = IDLE_CODE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      counter   <= '0;
      hiloValid <= 1'b0;
      functReg  <= IDLE_CODE;
      dp_dataA  <= '0;
      dp_dataB  <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            functReg <= req_funct;
            case (reqClass)
              OP_SINGLE: begin
                dp_dataA <= req_a;
                dp_dataB <= req_b;
                state    <= ST_ISSUE;
              end
              OP_MUL: begin
                dp_dataA <= req_a;
                dp_dataB <= req_b;
                counter  <= '0;
                state    <= ST_MUL_RUN;
              end
              OP_HILO_RD: begin
                if (hiloValid) begin
                  dp_dataA <= req_a;
                  dp_dataB <= req_b;
                  state    <= ST_ISSUE;
                end else begin
                  // Nothing in HiLo yet: answer with an error and leave
                  // the datapath untouched.
                  rsp_data <= '0;
                  rsp_err  <= 1'b1;
                  state    <= ST_RESP;
                end
              end
              default: begin
                rsp_data <= '0;
                rsp_err  <= 1'b1;
                state    <= ST_RESP;
              end
            endcase
          end
        end

        ST_ISSUE: begin
          rsp_data <= dp_result;
          rsp_err  <= 1'b0;
          state    <= ST_RESP;
        end

        ST_MUL_RUN: begin
          if (counter == MUL_LAST) begin
            counter <= '0;
            state   <= ST_HILO_WAIT;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end

        ST_HILO_WAIT: begin
          if (counter == HILO_LAST) begin
            counter   <= '0;
            hiloValid <= 1'b1;
            // MULTU has no data result; zero marks completion
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            state     <= ST_RESP;
          end else begin
            counter <= counter + CNT_W'(1);
          end
        end

        ST_RESP: begin
          if (rsp_ready) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Purpose: self-checking bench for alu_op_sequencer with a behavioural TotalALU stand-in.
// Latency: measured per transaction against the expected cycle counts.
// Backpressure: exercises rsp_ready held low and checks response stability.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int MUL_CYCLES = 32;
  localparam int HILO_LAT   = 1;
  localparam logic [5:0] IDLE_CODE = 6'b111111;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [5:0]  req_funct;
  logic [31:0] req_a, req_b;
  logic [5:0]  dp_signal;
  logic [31:0] dp_dataA, dp_dataB, dp_result;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err, busy;

  logic [5:0]  decFunct;
  opClass_t    decClass;

  int nChecks = 0;
  int nPass   = 0;

  // Reference model state: product of the last completed MULTU
  logic        mHiloValid = 1'b0;
  logic [63:0] mProd = '0;

  always #5 clk = ~clk;

  alu_op_sequencer #(
    .MUL_CYCLES (MUL_CYCLES),
    .HILO_LAT   (HILO_LAT),
    .IDLE_CODE  (IDLE_CODE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_funct (req_funct),
    .req_a     (req_a),
    .req_b     (req_b),
    .dp_signal (dp_signal),
    .dp_dataA  (dp_dataA),
    .dp_dataB  (dp_dataB),
    .dp_result (dp_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .busy      (busy)
  );

  alu_funct_decode uDec (
    .funct   (decFunct),
    .opClass (decClass)
  );

  function automatic logic [31:0] aluRef(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      FN_AND:  return a & b;
      FN_OR:   return a | b;
      FN_ADD:  return a + b;
      FN_SUB:  return a - b;
      FN_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      FN_SLL:  return b << a[4:0];
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  function automatic opClass_t classOf(input logic [5:0] f);
    if (f == 6'd36 || f == 6'd37 || f == 6'd32 || f == 6'd34 || f == 6'd42 || f == 6'd0)
      return OP_SINGLE;
    if (f == 6'd25) return OP_MUL;
    if (f == 6'd16 || f == 6'd18) return OP_HILO_RD;
    return OP_ILLEGAL;
  endfunction

  // TotalALU stand-in: combinational ALU, multiplier that latches HiLo
  // after MULTU has been presented for MUL_CYCLES consecutive cycles.
  logic [31:0] hiReg = '0, loReg = '0;
  int mulCnt = 0;
  always @(posedge clk) begin
    if (!reset) begin
      mulCnt <= 0;
    end else if (dp_signal == FN_MULTU) begin
      if (mulCnt == MUL_CYCLES - 1) begin
        {hiReg, loReg} <= {32'b0, dp_dataA} * {32'b0, dp_dataB};
        mulCnt <= 0;
      end else begin
        mulCnt <= mulCnt + 1;
      end
    end else begin
      mulCnt <= 0;
    end
  end

  always_comb begin
    dp_result = 32'hBAD0_BAD0;
    case (dp_signal)
      FN_MFHI:   dp_result = hiReg;
      FN_MFLO:   dp_result = loReg;
      IDLE_CODE: dp_result = 32'hBAD0_BAD0;
      default:   dp_result = aluRef(dp_signal, dp_dataA, dp_dataB);
    endcase
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
  endtask

  task automatic doOp(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b, input int hold);
    opClass_t    cls;
    logic        expErr;
    logic [31:0] expData;
    int expLat, expDp, k, dpAct, bad, w;
    cls     = classOf(f);
    expErr  = (cls == OP_ILLEGAL) || (cls == OP_HILO_RD && !mHiloValid);
    expData = 32'd0;
    expLat  = 2;
    expDp   = 1;
    if (expErr) begin
      expLat = 1;
      expDp  = 0;
    end else if (cls == OP_MUL) begin
      expLat = 1 + MUL_CYCLES + HILO_LAT;
      expDp  = MUL_CYCLES;
    end else if (f == FN_MFHI) expData = mProd[63:32];
    else if (f == FN_MFLO)     expData = mProd[31:0];
    else                       expData = aluRef(f, a, b);

    w = 0;
    @(negedge clk);
    while (!req_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    checkVal("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_funct = f;
    req_a     = a;
    req_b     = b;
    rsp_ready = (hold == 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_funct = 6'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;

    k = 0; dpAct = 0; bad = 0;
    do begin
      @(negedge clk);
      k++;
      if (dp_signal != IDLE_CODE) begin
        dpAct++;
        if (dp_signal != f) bad++;
      end
      if (!rsp_valid && (req_ready || !busy)) bad++;
    end while (!rsp_valid && k < 200);

    checkVal("latency",   32'(k),      32'(expLat));
    checkVal("dp_cycles", 32'(dpAct),  32'(expDp));
    checkVal("inflight",  32'(bad),    32'd0);
    checkVal("rsp_err",   32'(rsp_err), 32'(expErr));
    checkVal("rsp_data",  rsp_data,    expData);

    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkVal("hold_valid", 32'(rsp_valid), 32'd1);
      checkVal("hold_data",  rsp_data,       expData);
      checkVal("hold_err",   32'(rsp_err),   32'(expErr));
      checkVal("hold_ready", 32'(req_ready), 32'd0);
      checkVal("hold_busy",  32'(busy),      32'd1);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkVal("rsp_drop",  32'(rsp_valid), 32'd0);
    checkVal("data_keep", rsp_data,       expData);

    if (cls == OP_MUL && !expErr) begin
      mHiloValid = 1'b1;
      mProd      = {32'b0, a} * {32'b0, b};
    end
  endtask

  logic [5:0] legal [9];

  initial begin
    legal = '{FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_SLL, FN_MULTU, FN_MFHI, FN_MFLO};
    reset = 1'b0; req_valid = 1'b0; req_funct = '0; req_a = '0; req_b = '0;
    rsp_ready = 1'b1; decFunct = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("rst_busy",  32'(busy),      32'd0);
    checkVal("rst_valid", 32'(rsp_valid), 32'd0);
    checkVal("rst_ready", 32'(req_ready), 32'd1);
    checkVal("rst_sig",   32'(dp_signal), 32'(IDLE_CODE));
    checkVal("rst_dataA", dp_dataA,       32'd0);
    checkVal("rst_dataB", dp_dataB,       32'd0);
    checkVal("rst_data",  rsp_data,       32'd0);
    checkVal("rst_err",   32'(rsp_err),   32'd0);
    reset = 1'b1;

    for (int i = 0; i < 64; i++) begin
      decFunct = 6'(i);
      #1;
      checkVal("decode", 32'(decClass), 32'(classOf(6'(i))));
    end

    // Directed cases
    doOp(FN_MFHI, 32'd9, 32'd9, 0);              // no product yet -> error
    doOp(FN_ADD, 32'd5, 32'd7, 0);
    doOp(FN_SLT, 32'hFFFF_FFFF, 32'd1, 0);
    doOp(FN_SUB, 32'd3, 32'd5, 0);
    doOp(FN_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
    doOp(FN_MFHI, 32'd0, 32'd0, 0);
    doOp(FN_MFLO, 32'd0, 32'd0, 0);
    doOp(6'b111000, 32'd1, 32'd2, 5);

    // Reset in the middle of a multiply discards it and clears HiLo validity
    @(negedge clk);
    req_valid = 1'b1; req_funct = FN_MULTU; req_a = 32'd1234; req_b = 32'd5678;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    checkVal("mul_busy", 32'(dp_signal), 32'(FN_MULTU));
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    checkVal("mrst_busy",  32'(busy),      32'd0);
    checkVal("mrst_valid", 32'(rsp_valid), 32'd0);
    checkVal("mrst_sig",   32'(dp_signal), 32'(IDLE_CODE));
    checkVal("mrst_ready", 32'(req_ready), 32'd1);
    mHiloValid = 1'b0;
    doOp(FN_MFLO, 32'd0, 32'd0, 0);

    // Randomized traffic
    for (int n = 0; n < 40; n++) begin
      int sel, hold;
      logic [5:0] f;
      sel = $urandom_range(0, 10);
      if (sel < 9) f = legal[sel];
      else         f = 6'($urandom_range(0, 63));
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 4) : 0;
      doOp(f, $urandom, $urandom, hold);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
